// File: rtl/dot_product_accumulator_if.sv
// Product-in / sum-out bundle between the multiplier, the dot-product
// accumulator and the matrix result store.
interface dot_product_accumulator_if #(
  parameter int ACC_W = 66
);
  logic [63:0]      product;
  logic             product_valid;
  logic             clear;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready;
  logic             busy;
  logic             overrun;

  modport master (
    output product, product_valid, clear, sum_ready,
    input  sum, sum_valid, busy, overrun
  );

  modport slave (
    input  product, product_valid, clear, sum_ready,
    output sum, sum_valid, busy, overrun
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums every N consecutive 64-bit unsigned products into one exact ACC_W-bit
// dot product, presented on a held valid/ready output register.
module dot_product_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 66
) (
  input  logic                     clk,
  input  logic                     reset,
  dot_product_accumulator_if.slave bus
);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] final_sum;
  logic             accept;
  logic             complete;
  logic             out_free;

  assign accept    = bus.product_valid && !bus.clear;
  assign complete  = accept && (count == LAST);
  assign final_sum = acc + ACC_W'(bus.product);
  // The output slot can take a new sum if it is empty or drains this cycle.
  assign out_free  = !bus.sum_valid || bus.sum_ready;

  // Accumulation stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
    end else if (bus.clear || complete) begin
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      acc   <= final_sum;
      count <= count + CNT_W'(1);
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sum       <= '0;
      bus.sum_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else if (bus.clear) begin
      bus.sum_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (bus.sum_valid && bus.sum_ready)
        bus.sum_valid <= 1'b0;
      if (complete) begin
        if (out_free) begin
          bus.sum       <= final_sum;
          bus.sum_valid <= 1'b1;
        end else begin
          bus.overrun   <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (count != '0);
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed-vector bench for dot_product_accumulator with N=4, ACC_W=66.
module tb_dot_product_accumulator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dot_product_accumulator_if #(.ACC_W(66)) bus ();

  dot_product_accumulator #(.N(4), .ACC_W(66)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // One product pulse, followed by valid low; returns on the negedge after the edge.
  task automatic send(input logic [63:0] p);
    bus.product       = p;
    bus.product_valid = 1'b1;
    @(negedge clk);
    bus.product_valid = 1'b0;
  endtask

  task automatic burst(input logic [63:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      bus.product       = p;
      bus.product_valid = 1'b1;
      @(negedge clk);
    end
    bus.product_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++; if (bus.sum !== 66'd0) begin failures++; $display("FAIL reset_sum got=%0h exp=0", bus.sum); end
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL reset_sum_valid got=%b exp=0", bus.sum_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic;
    bus.sum_ready = 1'b1;
    send(64'd1);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_first got=%b exp=1", bus.busy); end
    idle(1);
    send(64'd2); idle(1);
    send(64'd3); idle(1);
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", bus.sum_valid); end
    send(64'd4);
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.sum_valid); end
    checks++; if (bus.sum !== 66'd10) begin failures++; $display("FAIL basic_sum got=%0d exp=10", bus.sum); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", bus.busy); end
    idle(1);
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", bus.sum_valid); end
  endtask

  task automatic test_wide;
    bus.sum_ready = 1'b1;
    burst(64'hFFFF_FFFE_0000_0001, 4);
    checks++; if (bus.sum !== 66'h3_FFFF_FFF8_0000_0004) begin failures++; $display("FAIL wide_sum got=%0h exp=3fffffff800000004", bus.sum); end
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL wide_valid got=%b exp=1", bus.sum_valid); end
    idle(1);
  endtask

  task automatic test_overrun;
    bus.sum_ready = 1'b0;
    burst(64'd1, 4);
    checks++; if (bus.sum !== 66'd4) begin failures++; $display("FAIL ovr_first_sum got=%0d exp=4", bus.sum); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_first_flag got=%b exp=0", bus.overrun); end
    burst(64'd2, 4);
    checks++; if (bus.sum !== 66'd4) begin failures++; $display("FAIL ovr_held_sum got=%0d exp=4", bus.sum); end
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_held got=%b exp=1", bus.sum_valid); end
    bus.sum_ready = 1'b1;
    idle(1);
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL ovr_valid_drop got=%b exp=0", bus.sum_valid); end
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
    bus.clear = 1'b1;
    idle(1);
    bus.clear = 1'b0;
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_back_to_back;
    bus.sum_ready = 1'b0;
    burst(64'd1, 4);
    burst(64'd2, 3);
    bus.sum_ready = 1'b1;
    send(64'd2);
    checks++; if (bus.sum !== 66'd8) begin failures++; $display("FAIL b2b_sum got=%0d exp=8", bus.sum); end
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", bus.sum_valid); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", bus.overrun); end
    idle(1);
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", bus.sum_valid); end
  endtask

  task automatic test_clear;
    bus.sum_ready = 1'b1;
    burst(64'd7, 2);
    bus.clear = 1'b1;
    send(64'd7);
    bus.clear = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", bus.busy); end
    burst(64'd5, 3);
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL clr_early_valid got=%b exp=0", bus.sum_valid); end
    send(64'd5);
    checks++; if (bus.sum !== 66'd20) begin failures++; $display("FAIL clr_sum got=%0d exp=20", bus.sum); end
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL clr_valid got=%b exp=1", bus.sum_valid); end
    idle(1);
  endtask

  task automatic test_async_reset;
    bus.sum_ready = 1'b0;
    burst(64'd3, 4);
    send(64'd1);
    send(64'd2);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL ares_busy_before got=%b exp=1", bus.busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.sum !== 66'd0) begin failures++; $display("FAIL ares_sum got=%0d exp=0", bus.sum); end
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL ares_valid got=%b exp=0", bus.sum_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ares_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    reset = 1'b0;
    bus.sum_ready = 1'b1;
    idle(1);
    send(64'd1); send(64'd2); send(64'd3); send(64'd4);
    checks++; if (bus.sum !== 66'd10) begin failures++; $display("FAIL ares_sum_after got=%0d exp=10", bus.sum); end
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL ares_valid_after got=%b exp=1", bus.sum_valid); end
    idle(1);
  endtask

  initial begin
    bus.product       = '0;
    bus.product_valid = 1'b0;
    bus.clear         = 1'b0;
    bus.sum_ready     = 1'b0;
    idle(2);
    test_reset();
    test_basic();
    test_wide();
    test_overrun();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
